// File: rtl/motor_drive_seq_if.sv
// Command/status bundle between the command/register logic and the
// motor_drive_seq block that feeds the PWM stage.
// master: the command side. slave: the sequencer.
interface motor_drive_seq_if #(
    parameter int W = 15
);
    logic         enable;
    logic [W-1:0] target;
    logic         dir_cmd;
    logic         estop;
    logic         tach;
    logic [W-1:0] ratio;
    logic         brake;
    logic         coast;
    logic         dir;
    logic         busy;
    logic         fault;

    modport master (
        output enable, target, dir_cmd, estop, tach,
        input  ratio, brake, coast, dir, busy, fault
    );

    modport slave (
        input  enable, target, dir_cmd, estop, tach,
        output ratio, brake, coast, dir, busy, fault
    );
endinterface

// File: rtl/motor_drive_seq.sv
// motor_drive_seq: per-channel sequencer for the PWM ratio/brake/coast inputs.
// Slews the duty ratio toward the commanded target, performs direction
// reversal as decelerate / dead time / reverse / ramp, and holds the brake
// for a minimum time after an emergency stop.
// Optional stall detection is compiled in with MOTOR_DRIVE_SEQ_STALL_DETECT_EN;
// without it tach is ignored and fault stays 0.
module motor_drive_seq #(
    parameter int W            = 15,
    parameter int RAMP_DIV     = 1000,
    parameter int STEP         = 16,
    parameter int DEAD_CYCLES  = 5000,
    parameter int BRAKE_CYCLES = 50000,
    parameter int TACH_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    motor_drive_seq_if.slave sif
);
    typedef enum logic [2:0] {IDLE, DRIVE, STOP, DEAD, BRAKE, FAULT} state_t;

    localparam int PW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int CNT_MAX = (DEAD_CYCLES > BRAKE_CYCLES) ? DEAD_CYCLES : BRAKE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [PW-1:0] presc_reg;
    logic          tick;
    state_t        state_reg;
    logic [W-1:0]  ratio_reg;
    logic          brake_reg;
    logic          coast_reg;
    logic          dir_reg;
    logic          busy_reg;
    logic          fault_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  goal;
    logic [W-1:0]  ramp_val;
    logic          stall_hit;

    // One slew step from cur toward goal, clamped so it never passes the goal.
    function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur, input logic [W-1:0] g);
        logic [W:0] up;
        logic [W:0] lim;
        logic [W-1:0] res;
        up  = {1'b0, cur} + (W+1)'(STEP);
        lim = {1'b0, g} + (W+1)'(STEP);
        res = cur;
        if (cur < g) begin
            res = (up >= {1'b0, g}) ? g : up[W-1:0];
        end else if (cur > g) begin
            res = ({1'b0, cur} <= lim) ? g : (cur - W'(STEP));
        end
        return res;
    endfunction

    assign tick = (presc_reg == PW'(RAMP_DIV - 1));

    // Free-running ramp prescaler; only reset clears it, state changes do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Goal is the live target while driving, zero while decelerating.
    always_comb begin
        goal     = (state_reg == DRIVE) ? sif.target : '0;
        ramp_val = ramp_step(ratio_reg, goal);
    end

`ifdef MOTOR_DRIVE_SEQ_STALL_DETECT_EN
    localparam int SW = $clog2(TACH_TIMEOUT + 1);

    logic [2:0]    tach_sync_reg;
    logic [SW-1:0] stall_cnt_reg;
    logic          tach_rise;
    logic          stall_run;

    assign tach_rise = tach_sync_reg[1] & ~tach_sync_reg[2];
    assign stall_run = (state_reg == DRIVE) && (ratio_reg != '0);
    assign stall_hit = stall_run && !tach_rise && (stall_cnt_reg == SW'(TACH_TIMEOUT - 1));

    // Two-flop synchronizer for tach plus one stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tach_sync_reg <= '0;
        end else begin
            tach_sync_reg <= {tach_sync_reg[1:0], sif.tach};
        end
    end

    // Cycles since the last tach edge while the motor should be turning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_run && !tach_rise) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end else begin
            stall_cnt_reg <= '0;
        end
    end
`else
    logic unused_tach;
    assign unused_tach = sif.tach | (TACH_TIMEOUT < 1);
    assign stall_hit   = 1'b0;
`endif

    // Main sequencer; every output is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ratio_reg <= '0;
            brake_reg <= 1'b0;
            coast_reg <= 1'b1;
            dir_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            fault_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (sif.estop && state_reg != FAULT) begin
            // Emergency stop: brake immediately; hold time counts from entry.
            state_reg <= BRAKE;
            ratio_reg <= '0;
            brake_reg <= 1'b1;
            coast_reg <= 1'b0;
            busy_reg  <= 1'b1;
            if (state_reg != BRAKE) begin
                cnt_reg <= '0;
            end else if (cnt_reg < CW'(BRAKE_CYCLES - 1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sif.enable) begin
                        state_reg <= DRIVE;
                        dir_reg   <= sif.dir_cmd;
                        coast_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (stall_hit) begin
                        state_reg <= FAULT;
                        ratio_reg <= '0;
                        coast_reg <= 1'b1;
                        fault_reg <= 1'b1;
                    end else begin
                        if (tick) ratio_reg <= ramp_val;
                        if (!sif.enable || sif.dir_cmd != dir_reg) state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (ratio_reg == '0) begin
                        state_reg <= DEAD;
                        coast_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else if (tick) begin
                        ratio_reg <= ramp_val;
                    end
                end
                DEAD: begin
                    if (cnt_reg >= CW'(DEAD_CYCLES - 1)) begin
                        cnt_reg <= '0;
                        if (sif.enable) begin
                            state_reg <= DRIVE;
                            dir_reg   <= sif.dir_cmd;
                            coast_reg <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BRAKE: begin
                    if (cnt_reg >= CW'(BRAKE_CYCLES - 1)) begin
                        state_reg <= DEAD;
                        brake_reg <= 1'b0;
                        coast_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FAULT: begin
                    if (!sif.enable) begin
                        state_reg <= IDLE;
                        fault_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ratio_reg <= '0;
                    brake_reg <= 1'b0;
                    coast_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sif.ratio = ratio_reg;
    assign sif.brake = brake_reg;
    assign sif.coast = coast_reg;
    assign sif.dir   = dir_reg;
    assign sif.busy  = busy_reg;
    assign sif.fault = fault_reg;
endmodule

// File: tb/tb_motor_drive_seq.sv
// Scoreboard bench for motor_drive_seq with short timing parameters.
// Stimulus pushes each expected output tuple (and how many cycles the previous
// tuple should have lasted) into a queue; the monitor pops one entry every time
// the sampled outputs change.
module tb_motor_drive_seq;
    localparam int W     = 15;
    localparam int RDIV  = 4;
    localparam int STP   = 16;
    localparam int DEADC = 8;
    localparam int BRKC  = 12;
    localparam int TACHT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motor_drive_seq_if #(.W(W)) bus ();

    motor_drive_seq #(
        .W(W), .RAMP_DIV(RDIV), .STEP(STP), .DEAD_CYCLES(DEADC),
        .BRAKE_CYCLES(BRKC), .TACH_TIMEOUT(TACHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sif(bus)
    );

    typedef struct packed {
        logic [W-1:0] ratio;
        logic         brake;
        logic         coast;
        logic         dir;
        logic         busy;
        logic         fault;
    } obs_t;

    typedef struct packed {
        obs_t o;
        int   hold;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic obs_t mk(input int r, input bit b, input bit c, input bit d,
                                input bit bz, input bit f);
        obs_t o;
        o.ratio = W'(r);
        o.brake = b;
        o.coast = c;
        o.dir   = d;
        o.busy  = bz;
        o.fault = f;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ratio = bus.ratio;
        o.brake = bus.brake;
        o.coast = bus.coast;
        o.dir   = bus.dir;
        o.busy  = bus.busy;
        o.fault = bus.fault;
        return o;
    endfunction

    task automatic push(input obs_t o, input int hold);
        exp_t e;
        e.o    = o;
        e.hold = hold;
        sbq.push_back(e);
    endtask

    // Driving-state tuple helper: ratio r, direction d, coast off, busy.
    function automatic obs_t drv(input int r, input bit d);
        return mk(r, 1'b0, 1'b0, d, 1'b1, 1'b0);
    endfunction

    task automatic check_now(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b, need ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b",
                     name, got.ratio, got.brake, got.coast, got.dir, got.busy, got.fault,
                     exp.ratio, exp.brake, exp.coast, exp.dir, exp.busy, exp.fault);
        end else begin
            $display("%s: ratio=%0d coast=%0b busy=%0b ok", name, got.ratio, got.coast, got.busy);
        end
    endtask

    task automatic at(input longint t);
        #(t - $time);
    endtask

    // Monitor: compares every output change against the next scoreboard entry.
    initial begin
        obs_t prev;
        obs_t cur;
        exp_t e;
        int   cnt;
        int   idx;
        prev = '0;
        cnt  = 0;
        idx  = 0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (rst) begin
                prev = cur;
                cnt  = 0;
            end else if (cur !== prev) begin
                n_vec++;
                idx++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL chg%0d unexpected: got ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b, need no change",
                             idx, cur.ratio, cur.brake, cur.coast, cur.dir, cur.busy, cur.fault);
                end else begin
                    e = sbq.pop_front();
                    if (cur !== e.o || (e.hold != 0 && cnt != e.hold)) begin
                        n_bad++;
                        $display("FAIL chg%0d: got ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b after %0d cycles, need ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b after %0d cycles",
                                 idx, cur.ratio, cur.brake, cur.coast, cur.dir, cur.busy, cur.fault, cnt,
                                 e.o.ratio, e.o.brake, e.o.coast, e.o.dir, e.o.busy, e.o.fault, e.hold);
                    end else begin
                        $display("chg%0d t=%0t: ratio=%0d brake=%0b coast=%0b dir=%0b busy=%0b fault=%0b held=%0d ok",
                                 idx, $time, cur.ratio, cur.brake, cur.coast, cur.dir, cur.busy, cur.fault, cnt);
                    end
                end
                prev = cur;
                cnt  = 1;
            end else begin
                cnt++;
            end
        end
    end

    // Directed stimulus; inputs change 2 time units after a falling edge.
    initial begin
        bus.enable  = 1'b0;
        bus.target  = '0;
        bus.dir_cmd = 1'b1;
        bus.estop   = 1'b0;
        bus.tach    = 1'b0;

        at(12);
        check_now("reset_state", mk(0, 0, 1, 0, 0, 0));

        // Ramp up to 100 from rest; ticks fall every 4 cycles.
        at(22);
        rst = 1'b0;
        bus.enable = 1'b1;
        bus.target = W'(100);
        push(drv(0, 1), 0);
        for (int k = 1; k <= 6; k++) push(drv(16 * k, 1), (k == 1) ? 3 : 4);
        push(drv(100, 1), 4);

        // Live target drop: step down without undershooting 40.
        at(302);
        bus.target = W'(40);
        push(drv(84, 1), 4);
        push(drv(68, 1), 4);
        push(drv(52, 1), 4);
        push(drv(40, 1), 4);

        // Back up to 100 (last step clamps 88 -> 100).
        at(462);
        bus.target = W'(100);
        push(drv(56, 1), 4);
        push(drv(72, 1), 4);
        push(drv(88, 1), 4);
        push(drv(100, 1), 4);

        // Direction reversal: decel, dead time, reverse, ramp again.
        at(622);
        bus.dir_cmd = 1'b0;
        push(drv(84, 1), 4);
        push(drv(68, 1), 4);
        push(drv(52, 1), 4);
        push(drv(36, 1), 4);
        push(drv(20, 1), 4);
        push(drv(4, 1), 4);
        push(drv(0, 1), 4);
        push(mk(0, 0, 1, 1, 1, 0), 1);
        push(drv(0, 0), DEADC);
        push(drv(16, 0), 3);
        push(drv(32, 0), 4);

        // Three-cycle estop pulse mid-ramp.
        at(1062);
        bus.estop = 1'b1;
        push(mk(0, 1, 0, 0, 1, 0), 1);
        push(mk(0, 0, 1, 0, 1, 0), BRKC);
        push(drv(0, 0), DEADC);
        push(drv(16, 0), 3);
        at(1092);
        bus.estop = 1'b0;

        // target=0 while driving: ramp to 0 and stay in drive.
        at(1302);
        bus.target = '0;
        push(drv(0, 0), 4);
        at(1342);
        bus.target = W'(100);
        push(drv(16, 0), 4);

        // Asynchronous reset between edges.
        at(1383);
        rst = 1'b1;
        #1;
        check_now("async_reset", mk(0, 0, 1, 0, 0, 0));
        at(1402);
        rst = 1'b0;
        bus.enable  = 1'b0;
        bus.dir_cmd = 1'b1;
        bus.target  = W'(20);
        at(1412);
        check_now("idle_after_reset", mk(0, 0, 1, 0, 0, 0));

        // Restart; clamps at 20.
        at(1432);
        bus.enable = 1'b1;
        push(drv(0, 1), 0);
        push(drv(16, 1), 4);
        push(drv(20, 1), 4);

`ifdef MOTOR_DRIVE_SEQ_STALL_DETECT_EN
        // No tach edges: stall fault after TACH_TIMEOUT cycles with ratio>0.
        push(mk(0, 0, 1, 1, 1, 1), 96);
        at(2482);
        bus.enable = 1'b0;
        push(mk(0, 0, 1, 1, 0, 0), 1);
        at(2492);
        bus.enable = 1'b1;
        push(drv(0, 1), 1);
        push(drv(16, 1), 2);
        push(drv(20, 1), 4);
        // Tach edge every 50 cycles keeps the stall counter below timeout.
        at(2522);
        for (int p = 0; p < 7; p++) begin
            bus.tach = 1'b1;
            #20;
            bus.tach = 1'b0;
            #480;
        end
        at(6100);
`else
        at(1600);
`endif

        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, need 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
